// File: rtl/vga_scene_addr.sv
// VGA 640x480@60 timing generator with incremental 2x-scaled background ROM addressing.
// All outputs are registered; hs/vs lag the counters by one cycle to match the RGB register stage.
module vga_scene_addr #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int IMG_W       = 320,
    parameter int SCALE_SHIFT = 1
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  drawX,
    output logic [9:0]  drawY,
    output logic        blank,
    output logic [16:0] rom_address,
    output logic        hs,
    output logic        vs,
    output logic        frame_start,
    output logic        frame_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_MAX     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_MAX     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS     = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS     = 10'(V_VISIBLE);
    localparam logic [9:0]  HS_FIRST  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0]  HS_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_FIRST  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]  VS_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [16:0] ROW_STEP  = 17'(IMG_W);

    logic [9:0]  draw_x_q, draw_x_d;
    logic [9:0]  draw_y_q, draw_y_d;
    logic        blank_q, blank_d;
    logic [16:0] rom_address_q, rom_address_d;
    logic [16:0] row_base_q, row_base_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_end_q, frame_end_d;
    logic        line_wrap;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        line_wrap     = (draw_x_q == H_MAX);
        draw_x_d      = line_wrap ? 10'd0 : draw_x_q + 10'd1;
        draw_y_d      = draw_y_q;
        row_base_d    = row_base_q;
        rom_address_d = rom_address_q;

        if (line_wrap) begin
            draw_y_d = (draw_y_q == V_MAX) ? 10'd0 : draw_y_q + 10'd1;
            if (draw_y_d == 10'd0) begin
                row_base_d = '0;
            end else if (draw_y_d[SCALE_SHIFT-1:0] == '0 && draw_y_d < V_VIS) begin
                row_base_d = row_base_q + ROW_STEP;
            end
        end

        // Source column advances once per replicated pixel; frozen through blanking.
        if (draw_x_d == 10'd0) begin
            rom_address_d = row_base_d;
        end else if (draw_x_d < H_VIS && draw_x_d[SCALE_SHIFT-1:0] == '0) begin
            rom_address_d = rom_address_q + 17'd1;
        end

        blank_d       = (draw_x_d < H_VIS) && (draw_y_d < V_VIS);
        hs_d          = ~(draw_x_q >= HS_FIRST && draw_x_q <= HS_LAST);
        vs_d          = ~(draw_y_q >= VS_FIRST && draw_y_q <= VS_LAST);
        frame_start_d = (draw_x_d == 10'd0) && (draw_y_d == 10'd0);
        frame_end_d   = (draw_x_d == 10'd0) && (draw_y_d == V_VIS);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from the same old values.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            draw_x_q      <= H_MAX;
            draw_y_q      <= V_MAX;
            blank_q       <= 1'b0;
            rom_address_q <= '0;
            row_base_q    <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            draw_x_q      <= draw_x_d;
            draw_y_q      <= draw_y_d;
            blank_q       <= blank_d;
            rom_address_q <= rom_address_d;
            row_base_q    <= row_base_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign drawX       = draw_x_q;
    assign drawY       = draw_y_q;
    assign blank       = blank_q;
    assign rom_address = rom_address_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;

endmodule
